maxpool2d_stream: RTL and testbench
===================================

Name: maxpool2d_stream

Overview:
- Streaming 2x2, stride-2 max-pool stage directly downstream of the conv2d top; consumes its output pixel stream (valid + 16-bit data).
- Input order is raster within a channel, then channel after channel. Each pooled pixel is written with its own linear output address.
- Selected when the Maxpool bit of the control word is set. The controller pulses i_start with the same width/height/channel config used for conv.

Parameters:
- DATA_WIDTH, 16, pixel width (signed two's complement)
- MAX_WIDTH, 416, largest supported input width; sets line-buffer depth MAX_WIDTH/2
- ADDR_WIDTH, 18, output address width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; latches config and begins a run
- i_max_width  in  9  input columns per row
- i_max_height  in  9  input rows per channel
- i_max_co  in  10  number of channels in the stream
- i_valid  in  1  input sample strobe
- i_data  in  DATA_WIDTH  input sample (signed)
- o_valid  out  1  pooled sample strobe
- o_data  out  DATA_WIDTH  pooled sample
- o_addr  out  ADDR_WIDTH  write address of o_data
- o_done  out  1  one-cycle pulse at end of run
- o_busy  out  1  high while in RUN

Behaviour:
- Reset (i_rst=0, asynchronous): state IDLE; all counters, line buffer valid flags and pair register cleared; o_valid=0, o_data=0, o_addr=0, o_done=0, o_busy=0.
- State IDLE:
  - On i_start, latch width, height and channel count; clear col/row/ch counters and the output address counter.
  - If width<2, height<2 or co==0, go to FIN. Otherwise go to RUN.
  - i_valid is ignored in IDLE.
- State RUN: each i_valid advances col. At col==width-1 col wraps to 0 and row advances. At row==height-1 row wraps to 0 and ch advances.
  - Horizontal pair: on even col, hold the sample in the pair register. On odd col, hmax = signed max(pair, i_data).
  - Even row: write hmax to line buffer at index col>>1.
  - Odd row: compare hmax with line buffer[col>>1]; the signed max is the output.
  - Output latency: o_valid goes high one cycle after the accepted sample that completes a window, with o_data registered. o_addr then holds the current address count, and the count increments after each output.
  - Odd boundary: the last column when width is odd and the last row when height is odd are consumed but never pooled. Output per channel is floor(W/2) x floor(H/2).
  - Ties: equal values give that value. Comparison is signed; e.g. 0x8000 < 0x0000.
  - The line buffer is not cleared between rows or channels; even-row writes always precede odd-row reads.
  - The last sample of the last channel causes a transition to FIN.
- State FIN:
  - o_done=1 for exactly one cycle, aligned with or after the final o_valid (never before).
  - Then IDLE; o_addr returns to 0 on the next i_start.
- i_start while in RUN or FIN is ignored. i_valid in FIN is ignored.
- No back-pressure: the block accepts i_valid every cycle, back-to-back.
- o_addr wraps modulo 2^ADDR_WIDTH. The controller guarantees no wrap for legal sizes.

Optional Feature:
- MAXPOOL_RELU_EN defined: each pooled result is clamped so negatives become 0 before o_data. This lets Bn&ReLU be skipped when only ReLU is needed. Latency is unchanged.
- Not defined: o_data is the raw signed max.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/RUN/FIN
  - DATA_WIDTH default
  - the control-word bit positions (start, done, conv, bn, maxpool, layer[3:0]) used by the controller
- One natural sub-module: maxpool_line_buf.
  - Single-port-per-side RAM, depth MAX_WIDTH/2, DATA_WIDTH wide.
  - Synchronous write; read address presented a cycle early, or combinational read, so the odd-row compare stays at one-cycle latency.
  - Counters and compare logic stay in the top.

Test Plan:
- 4x4, co=1, values 0..15 raster, back-to-back valid -> 4 outputs: 5,7,13,15 at addr 0..3; o_done one cycle after the last output.
- 5x3, co=1, values 0..14 -> 2 outputs: 6,8 at addr 0,1; column 4 and row 2 are consumed without output; done once.
- 4x4, co=3, channel k values = 16k+i -> 12 outputs, addr 0..11, values 5,7,13,15,21,...,47; no cross-channel mixing.
- Signed data: window {0x8000,0xFFFF,0x0001,0x7FFF} -> 0x7FFF; window of all 0xFFF0 -> 0xFFF0 (0x0000 with MAXPOOL_RELU_EN).
- Gapped valid: random 1-3 idle cycles between samples of a 4x4 -> same outputs as the back-to-back case. Also i_start with width=1 -> o_done pulse, zero outputs.
- Reset mid-run: assert i_rst after 6 samples of a 4x4 -> outputs 0 and state IDLE immediately. A fresh i_start then yields the correct 4 results from addr 0.

Source files
------------

// File: rtl/maxpool2d_stream_pkg.sv
// Shared definitions for the maxpool2d_stream stage: FSM states, default pixel
// width and the controller's control-word bit positions.
package maxpool2d_stream_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_DONE_BIT    = 1;
  localparam int CTRL_CONV_BIT    = 2;
  localparam int CTRL_BN_BIT      = 3;
  localparam int CTRL_MAXPOOL_BIT = 4;
  localparam int CTRL_LAYER_LSB   = 5;
  localparam int CTRL_LAYER_MSB   = 8;

endpackage

// File: rtl/maxpool_line_buf.sv
// One-row buffer of horizontal pair maxima; synchronous write, combinational
// read so the odd-row compare completes in the same cycle as the sample.
module maxpool_line_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 208,
  parameter int AW         = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster, channel-major stream.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool2d_stream
  import maxpool2d_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MAX_WIDTH  = 416,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [8:0]            i_max_width,
  input  logic [8:0]            i_max_height,
  input  logic [9:0]            i_max_co,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_done,
  output logic                  o_busy
);

  localparam int LB_DEPTH = MAX_WIDTH / 2;
  localparam int LB_AW    = $clog2(LB_DEPTH);

  state_e state_q, state_d;

  logic [8:0]                   width_q, height_q, col_q, row_q;
  logic [9:0]                   co_q, ch_q;
  logic signed [DATA_WIDTH-1:0] pair_q;
  logic [ADDR_WIDTH-1:0]        addrCnt_q, oAddr_q;
  logic [DATA_WIDTH-1:0]        oData_q;
  logic                         oValid_q, oDone_q;

  logic signed [DATA_WIDTH-1:0] dataS, hmax, lbRd, vmax, result;
  logic [DATA_WIDTH-1:0]        lbRdRaw;
  logic [LB_AW-1:0]             lbIdx;
  logic                         accept, lastCol, lastRow, lastCh, fire, lbWe, cfgBad;

  assign accept  = (state_q == RUN) && i_valid;
  assign lastCol = (col_q == width_q - 9'd1);
  assign lastRow = (row_q == height_q - 9'd1);
  assign lastCh  = (ch_q == co_q - 10'd1);
  assign cfgBad  = (i_max_width < 9'd2) || (i_max_height < 9'd2) || (i_max_co == 10'd0);

  // Odd col closes a horizontal pair; even rows stash it, odd rows pool it.
  assign dataS = i_data;
  assign hmax  = (dataS > pair_q) ? dataS : pair_q;
  assign lbRd  = lbRdRaw;
  assign vmax  = (hmax > lbRd) ? hmax : lbRd;
  assign fire  = accept && col_q[0] && row_q[0];
  assign lbWe  = accept && col_q[0] && !row_q[0];
  assign lbIdx = LB_AW'(col_q >> 1);

`ifdef MAXPOOL_RELU_EN
  assign result = vmax[DATA_WIDTH-1] ? '0 : vmax;
`else
  assign result = vmax;
`endif

  maxpool_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (LB_DEPTH),
    .AW        (LB_AW)
  ) u_line_buf (
    .i_clk  (i_clk),
    .i_we   (lbWe),
    .i_waddr(lbIdx),
    .i_wdata(hmax),
    .i_raddr(lbIdx),
    .o_rdata(lbRdRaw)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = cfgBad ? FIN : RUN;
      RUN:     if (accept && lastCol && lastRow && lastCh) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      width_q   <= '0;
      height_q  <= '0;
      co_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      pair_q    <= '0;
      addrCnt_q <= '0;
      oAddr_q   <= '0;
      oData_q   <= '0;
      oValid_q  <= 1'b0;
      oDone_q   <= 1'b0;
    end else begin
      oValid_q <= fire;
      oDone_q  <= (state_q == FIN);
      if (state_q == IDLE && i_start) begin
        width_q   <= i_max_width;
        height_q  <= i_max_height;
        co_q      <= i_max_co;
        col_q     <= '0;
        row_q     <= '0;
        ch_q      <= '0;
        addrCnt_q <= '0;
        oAddr_q   <= '0;
      end
      if (accept) begin
        if (!col_q[0]) pair_q <= dataS;
        if (lastCol) begin
          col_q <= '0;
          if (lastRow) begin
            row_q <= '0;
            ch_q  <= ch_q + 10'd1;
          end else begin
            row_q <= row_q + 9'd1;
          end
        end else begin
          col_q <= col_q + 9'd1;
        end
      end
      if (fire) begin
        oData_q   <= result;
        oAddr_q   <= addrCnt_q;
        addrCnt_q <= addrCnt_q + 1'b1;
      end
    end
  end

  assign o_valid = oValid_q;
  assign o_data  = oData_q;
  assign o_addr  = oAddr_q;
  assign o_done  = oDone_q;
  assign o_busy  = (state_q == RUN);

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Scoreboard bench for maxpool2d_stream: directed runs push expected pooled
// samples, a negedge monitor pops and compares whenever o_valid is seen.
module tb_maxpool2d_stream;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [8:0]  maxWidth, maxHeight;
  logic [9:0]  maxCo;
  logic        inValid;
  logic [15:0] inData;
  logic        outValid;
  logic [15:0] outData;
  logic [17:0] outAddr;
  logic        outDone, outBusy;

  int passCount  = 0;
  int checkCount = 0;

  logic [15:0] expData[$];
  logic [17:0] expAddr[$];
  logic [15:0] popData;
  logic [17:0] popAddr;

  maxpool2d_stream dut (
    .i_clk       (clk),
    .i_rst       (rstN),
    .i_start     (start),
    .i_max_width (maxWidth),
    .i_max_height(maxHeight),
    .i_max_co    (maxCo),
    .i_valid     (inValid),
    .i_data      (inData),
    .o_valid     (outValid),
    .o_data      (outData),
    .o_addr      (outAddr),
    .o_done      (outDone),
    .o_busy      (outBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected bench end");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expectOut(input logic [15:0] d, input logic [17:0] a);
    expData.push_back(d);
    expAddr.push_back(a);
  endtask

  // Monitor: every presented output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstN && outValid) begin
      if (expData.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_output: got data 0x%0h addr %0d, expected none", outData, outAddr);
      end else begin
        popData = expData.pop_front();
        popAddr = expAddr.pop_front();
        checkOutput("o_data", {16'h0, outData}, {16'h0, popData});
        checkOutput("o_addr", {14'h0, outAddr}, {14'h0, popAddr});
      end
    end
  end

  task automatic startRun(input int w, input int h, input int c);
    @(posedge clk); #1;
    start     = 1'b1;
    maxWidth  = 9'(w);
    maxHeight = 9'(h);
    maxCo     = 10'(c);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] d, input int gap);
    inValid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    inValid = 1'b1;
    inData  = d;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic waitDone(input logic expectPrevValid);
    bit   seen;
    logic prev;
    seen = 0;
    prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (outDone) begin
        seen = 1;
        break;
      end
      prev = outValid;
    end
    if (!seen) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("valid_before_done", {31'h0, prev}, {31'h0, expectPrevValid});
      @(negedge clk);
      checkOutput("done_one_cycle", {31'h0, outDone}, 32'd0);
      checkOutput("queue_drained", expData.size(), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] negA, negB;
    rstN      = 1'b0;
    start     = 1'b0;
    maxWidth  = '0;
    maxHeight = '0;
    maxCo     = '0;
    inValid   = 1'b0;
    inData    = '0;
    #12;
    checkOutput("reset_valid", {31'h0, outValid}, 32'd0);
    checkOutput("reset_data", {16'h0, outData}, 32'd0);
    checkOutput("reset_addr", {14'h0, outAddr}, 32'd0);
    checkOutput("reset_done", {31'h0, outDone}, 32'd0);
    checkOutput("reset_busy", {31'h0, outBusy}, 32'd0);
    rstN = 1'b1;

    $display("[TB] 4x4 single channel, back-to-back");
    expectOut(16'd5, 18'd0); expectOut(16'd7, 18'd1);
    expectOut(16'd13, 18'd2); expectOut(16'd15, 18'd3);
    startRun(4, 4, 1);
    checkOutput("busy_in_run", {31'h0, outBusy}, 32'd1);
    for (int i = 0; i < 16; i++) applyStimulus(16'(i), 0);
    waitDone(1'b1);
    checkOutput("busy_after_done", {31'h0, outBusy}, 32'd0);

    $display("[TB] 5x3 odd boundaries");
    expectOut(16'd6, 18'd0); expectOut(16'd8, 18'd1);
    startRun(5, 3, 1);
    for (int i = 0; i < 15; i++) applyStimulus(16'(i), 0);
    waitDone(1'b0);

    $display("[TB] 4x4 three channels");
    for (int k = 0; k < 3; k++) begin
      expectOut(16'(16*k + 5), 18'(4*k));
      expectOut(16'(16*k + 7), 18'(4*k + 1));
      expectOut(16'(16*k + 13), 18'(4*k + 2));
      expectOut(16'(16*k + 15), 18'(4*k + 3));
    end
    startRun(4, 4, 3);
    for (int i = 0; i < 48; i++) applyStimulus(16'(i), 0);
    waitDone(1'b1);

    $display("[TB] signed windows");
    expectOut(16'h7FFF, 18'd0);
    startRun(2, 2, 1);
    applyStimulus(16'h8000, 0); applyStimulus(16'hFFFF, 0);
    applyStimulus(16'h0001, 0); applyStimulus(16'h7FFF, 0);
    waitDone(1'b1);
`ifdef MAXPOOL_RELU_EN
    negA = 16'h0000;
    negB = 16'h0000;
`else
    negA = 16'hFFF0;
    negB = 16'hFFFE;
`endif
    expectOut(negA, 18'd0);
    startRun(2, 2, 1);
    for (int i = 0; i < 4; i++) applyStimulus(16'hFFF0, 0);
    waitDone(1'b1);
    expectOut(negB, 18'd0);
    startRun(2, 2, 1);
    applyStimulus(16'h8001, 0); applyStimulus(16'hFFFD, 0);
    applyStimulus(16'h8000, 0); applyStimulus(16'hFFFE, 0);
    waitDone(1'b1);

    $display("[TB] 4x4 gapped valid");
    expectOut(16'd5, 18'd0); expectOut(16'd7, 18'd1);
    expectOut(16'd13, 18'd2); expectOut(16'd15, 18'd3);
    startRun(4, 4, 1);
    for (int i = 0; i < 16; i++) applyStimulus(16'(i), $urandom_range(1, 3));
    waitDone(1'b1);

    $display("[TB] width 1 degenerate run");
    startRun(1, 4, 1);
    applyStimulus(16'h0042, 0);
    waitDone(1'b0);

    $display("[TB] reset mid-run");
    startRun(4, 4, 1);
    for (int i = 0; i < 6; i++) applyStimulus(16'(i), 0);
    rstN = 1'b0;
    #1;
    checkOutput("midreset_valid", {31'h0, outValid}, 32'd0);
    checkOutput("midreset_data", {16'h0, outData}, 32'd0);
    checkOutput("midreset_addr", {14'h0, outAddr}, 32'd0);
    checkOutput("midreset_busy", {31'h0, outBusy}, 32'd0);
    #2;
    rstN = 1'b1;
    expectOut(16'd5, 18'd0); expectOut(16'd7, 18'd1);
    expectOut(16'd13, 18'd2); expectOut(16'd15, 18'd3);
    startRun(4, 4, 1);
    for (int i = 0; i < 16; i++) applyStimulus(16'(i), 0);
    waitDone(1'b1);

    repeat (3) @(negedge clk);
    checkOutput("final_queue_empty", expData.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
